// File: rtl/apb4_slave_if_if.sv
// APB4 bus bundle between a requester and the apb4_slave_if completer.
interface apb4_slave_if_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [2:0]              PPROT;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_slave_if.sv
// APB4 completer backed by a word-addressed register array, with a fixed
// number of wait states, byte-lane write strobes and an address-error response.
module apb4_slave_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic            PCLK,
    input logic            PRESETn,  // active-high despite the name
    apb4_slave_if_if.slave apb
);
    localparam int unsigned LANES    = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(LANES);
    localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W    = 4;

    // The setup phase is recognised in s_idle (or s_done for back-to-back
    // restarts); s_access counts wait states, s_done is the PREADY=1 cycle.
    localparam logic [1:0] s_idle   = 2'd0;
    localparam logic [1:0] s_access = 2'd1;
    localparam logic [1:0] s_done   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic                  addr_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  start, finish, wr_en;
    logic                  unused_pprot;

    assign unused_pprot = ^apb.PPROT;

    // Address decode: word index, misalignment and range errors.
    always_comb begin
        word_idx = apb.PADDR >> ADDR_LSB;
        mem_idx  = word_idx[IDX_W-1:0];
        addr_err = ((apb.PADDR & ADDR_WIDTH'(LANES - 1)) != '0) ||
                   (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
        rd_word  = addr_err ? '0 : mem_q[mem_idx];
    end

    // Next-state logic; response outputs are registered on entry to s_done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            s_idle: start = apb.PSEL && !apb.PENABLE;
            s_access: begin
                if (!apb.PSEL) begin
                    state_d = s_idle;
                end else if (!apb.PENABLE) begin
                    start = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    finish = (cnt_q == 4'd1);
                end
            end
            s_done: begin
                state_d = s_idle;
                start   = apb.PSEL && !apb.PENABLE;
            end
            default: state_d = s_idle;
        endcase
        if (start) begin
            cnt_d = CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
                finish = 1'b1;
            end else begin
                state_d = s_access;
            end
        end
        if (finish) begin
            state_d = s_done;
            cnt_d   = '0;
        end
        pready_d  = finish;
        pslverr_d = finish && addr_err;
        prdata_d  = prdata_q;
        if (finish) begin
            if (addr_err) begin
                prdata_d = '0;
            end else if (!apb.PWRITE) begin
                prdata_d = rd_word;
            end
        end
    end

    assign wr_en = (state_q == s_done) && apb.PSEL && apb.PENABLE && apb.PWRITE && !addr_err;

    // Control and response registers.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_q   <= s_idle;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Storage array: strobed byte-lane writes on the completing edge.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            for (int w = 0; w < int'(MEM_DEPTH); w++) begin
                mem_q[w] <= '0;
            end
        end else if (wr_en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (apb.PSTRB[l]) begin
                    mem_q[mem_idx][8*l +: 8] <= apb.PWDATA[8*l +: 8];
                end
            end
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb4_slave_if.sv
// Bench for apb4_slave_if: one instance with no wait states and one with two,
// directed vector table, hand-written corner sequences and random transfers
// checked against a behavioural memory model.
module tb_apb4_slave_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  psel_v = 2'b00;
    logic        penable_v = 1'b0;
    logic        pwrite_v = 1'b0;
    logic [31:0] paddr_v = '0;
    logic [31:0] pwdata_v = '0;
    logic [3:0]  pstrb_v = '0;

    apb4_slave_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    apb4_slave_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.PSEL = psel_v[0];
    assign bus0.PENABLE = penable_v;
    assign bus0.PWRITE = pwrite_v;
    assign bus0.PADDR = paddr_v;
    assign bus0.PWDATA = pwdata_v;
    assign bus0.PSTRB = pstrb_v;
    assign bus0.PPROT = 3'b010;
    assign bus2.PSEL = psel_v[1];
    assign bus2.PENABLE = penable_v;
    assign bus2.PWRITE = pwrite_v;
    assign bus2.PADDR = paddr_v;
    assign bus2.PWDATA = pwdata_v;
    assign bus2.PSTRB = pstrb_v;
    assign bus2.PPROT = 3'b001;

    apb4_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst), .apb(bus0)
    );
    apb4_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .WAIT_STATES(2)) dut2 (
        .PCLK(clk), .PRESETn(rst), .apb(bus2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-instance word array and last presented read data.
    logic [31:0] mdl [2][32];
    logic [31:0] last_rd [2];

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, id, act, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int d);
        return (d == 0) ? bus0.PRDATA : bus2.PRDATA;
    endfunction
    function automatic logic ready_of(input int d);
        return (d == 0) ? bus0.PREADY : bus2.PREADY;
    endfunction
    function automatic logic err_of(input int d);
        return (d == 0) ? bus0.PSLVERR : bus2.PSLVERR;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 32; w++) mdl[d][w] = '0;
            last_rd[d] = '0;
        end
    endtask

    // Expected response of a transfer, then apply its effect on the model.
    task automatic model_xfer(input int d, input logic wr, input logic [31:0] a,
                              input logic [31:0] data, input logic [3:0] strb,
                              output logic [31:0] exp_rd, output logic exp_er);
        logic [31:0] mask;
        exp_er = (a % 4 != 0) || (a / 4 >= 32);
        if (exp_er) begin
            exp_rd = '0;
            last_rd[d] = '0;
        end else if (wr) begin
            exp_rd = last_rd[d];
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            mdl[d][a / 4] = (mdl[d][a / 4] & ~mask) | (data & mask);
        end else begin
            exp_rd = mdl[d][a / 4];
            last_rd[d] = exp_rd;
        end
    endtask

    // One APB transfer; entered just after a rising edge, returns just after
    // the completing edge with the bus idle (or ready for back-to-back).
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er, output int cycles);
        psel_v = (d == 0) ? 2'b01 : 2'b10;
        penable_v = 1'b0;
        pwrite_v = wr;
        paddr_v = a;
        pwdata_v = data;
        pstrb_v = strb;
        cycles = 1;
        @(posedge clk); #1;
        penable_v = 1'b1;
        cycles = 2;
        while (!ready_of(d) && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        rd = rdata_of(d);
        er = err_of(d);
        @(posedge clk); #1;
        psel_v = 2'b00;
        penable_v = 1'b0;
        check("pready_one_cycle", d, {31'b0, ready_of(d)}, 32'd0);
        check("pslverr_low_idle", d, {31'b0, err_of(d)}, 32'd0);
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd, exp_rd, a, data;
        logic er, exp_er, wr;
        logic [3:0] strb;
        int cyc, d;

        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, exp_rd, a, data;
        logic er, exp_er, wr;
        logic [3:0] strb;
        int cyc, d;

        tbl[0]  = '{0, 1'b0, 32'h00, 32'h0,        4'h0,    32'h0,        1'b0};
        tbl[1]  = '{0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
        tbl[2]  = '{0, 1'b0, 32'h04, 32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
        tbl[3]  = '{0, 1'b1, 32'h08, 32'h11223344, 4'hF,    32'hDEADBEEF, 1'b0};
        tbl[4]  = '{0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{0, 1'b0, 32'h08, 32'h0,        4'h0,    32'h11BB33DD, 1'b0};
        tbl[6]  = '{0, 1'b1, 32'h00, 32'hCAFEF00D, 4'hF,    32'h11BB33DD, 1'b0};
        tbl[7]  = '{0, 1'b0, 32'h80, 32'h0,        4'h0,    32'h0,        1'b1};
        tbl[8]  = '{0, 1'b1, 32'h02, 32'h12345678, 4'hF,    32'h0,        1'b1};
        tbl[9]  = '{0, 1'b0, 32'h00, 32'h0,        4'h0,    32'hCAFEF00D, 1'b0};
        tbl[10] = '{0, 1'b1, 32'h0C, 32'h55555555, 4'h0,    32'hCAFEF00D, 1'b0};
        tbl[11] = '{0, 1'b0, 32'h0C, 32'h0,        4'h0,    32'h0,        1'b0};
        tbl[12] = '{0, 1'b0, 32'h04, 32'h0,        4'hF,    32'hDEADBEEF, 1'b0};
        tbl[13] = '{1, 1'b1, 32'h10, 32'h01020304, 4'hF,    32'h0,        1'b0};
        tbl[14] = '{1, 1'b0, 32'h10, 32'h0,        4'h0,    32'h01020304, 1'b0};
        tbl[15] = '{1, 1'b0, 32'h7C, 32'h0,        4'h0,    32'h0,        1'b0};

        // Reset state
        model_reset();
        #20;
        check("rst_pready", 0, {31'b0, bus0.PREADY}, 32'd0);
        check("rst_pslverr", 0, {31'b0, bus0.PSLVERR}, 32'd0);
        check("rst_prdata", 0, bus0.PRDATA, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_pready", 1, {31'b0, bus2.PREADY}, 32'd0);
        check("post_rst_prdata", 1, bus2.PRDATA, 32'd0);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            model_xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb,
                       exp_rd, exp_er);
            xfer(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, rd, er, cyc);
            check("tbl_latency", i, cyc, (tbl[i].d == 0) ? 32'd2 : 32'd4);
            check("tbl_pslverr", i, {31'b0, er}, {31'b0, tbl[i].exp_er});
            check("tbl_prdata", i, rd, tbl[i].exp_rd);
        end

        // PSEL dropped mid-ACCESS on the wait-state instance: no write
        psel_v = 2'b10; penable_v = 1'b0; pwrite_v = 1'b1;
        paddr_v = 32'h10; pwdata_v = 32'hFFFFFFFF; pstrb_v = 4'hF;
        @(posedge clk); #1;
        penable_v = 1'b1;
        @(posedge clk); #1;
        check("abort_pready", 0, {31'b0, bus2.PREADY}, 32'd0);
        psel_v = 2'b00; penable_v = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_idle_pready", 0, {31'b0, bus2.PREADY}, 32'd0);
        model_xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, exp_rd, exp_er);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        check("abort_nowrite", 0, rd, exp_rd);

        // Back-to-back writes, then reset during ACCESS of a third
        model_xfer(0, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, exp_rd, exp_er);
        xfer(0, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, rd, er, cyc);
        check("b2b_latency", 0, cyc, 32'd2);
        model_xfer(0, 1'b1, 32'h18, 32'h600DCAFE, 4'hF, exp_rd, exp_er);
        xfer(0, 1'b1, 32'h18, 32'h600DCAFE, 4'hF, rd, er, cyc);
        check("b2b_latency", 1, cyc, 32'd2);
        psel_v = 2'b01; penable_v = 1'b0; pwrite_v = 1'b1;
        paddr_v = 32'h14; pwdata_v = 32'h12121212; pstrb_v = 4'hF;
        @(posedge clk); #1;
        penable_v = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_pready", 0, {31'b0, bus0.PREADY}, 32'd0);
        check("midrst_pslverr", 0, {31'b0, bus0.PSLVERR}, 32'd0);
        check("midrst_prdata", 0, bus0.PRDATA, 32'd0);
        @(posedge clk); #1;
        psel_v = 2'b00; penable_v = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        model_xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, exp_rd, exp_er);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
        check("midrst_word", 0, rd, exp_rd);

        // Randomized transfers against the model
        for (int i = 0; i < 200; i++) begin
            d = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, 31)) * 4;
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            model_xfer(d, wr, a, data, strb, exp_rd, exp_er);
            xfer(d, wr, a, data, strb, rd, er, cyc);
            check("rnd_latency", i, cyc, (d == 0) ? 32'd2 : 32'd4);
            check("rnd_pslverr", i, {31'b0, er}, {31'b0, exp_er});
            check("rnd_prdata", i, rd, exp_rd);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
